// File: rtl/io_pio_pkg.sv
// Shared definitions for the key-capture peripheral: register map and counter sizing helper.
package io_pio_pkg;

    localparam logic [7:0] REG_DATA = 8'h00;
    localparam logic [7:0] REG_EDGE = 8'h04;
    localparam logic [7:0] REG_MASK = 8'h08;

    // Bits needed to hold 0 .. value-1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((64'd1 << result) < 64'(value)) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/io_key_capture_if.sv
// Hub-side register bus for the key-capture peripheral.
interface io_key_capture_if;

    logic [7:0]  addr;
    logic [31:0] datain;
    logic        we;
    logic [31:0] dataout;
    logic        irq;

    modport master (
        output addr,
        output datain,
        output we,
        input  dataout,
        input  irq
    );

    modport slave (
        input  addr,
        input  datain,
        input  we,
        output dataout,
        output irq
    );

endinterface

// File: rtl/io_debounce.sv
// One key: 2-flop synchroniser, polarity normalisation and a stability counter.
module io_debounce
    import io_pio_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic pin,
    output logic stable,
    output logic rise_pulse
);

    localparam int unsigned     CntW     = clog2(DEBOUNCE_CYCLES);
    localparam logic [CntW-1:0] CntMax   = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic            Released = ACTIVE_LOW;

    logic            sync1_q, sync2_q;
    logic            pressed;
    logic            stable_q, stable_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            accept;

    // Reset loads the released level so no press is seen coming out of reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= Released;
            sync2_q <= Released;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
        end
    end

    assign pressed = ACTIVE_LOW ? ~sync2_q : sync2_q;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        accept   = 1'b0;
        if (pressed != stable_q) begin
            if (cnt_q == CntMax) begin
                accept   = 1'b1;
                stable_d = pressed;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable     = stable_q;
    // Asserted in the cycle the press is accepted, so it lands with the stable update.
    assign rise_pulse = accept & pressed;

endmodule

// File: rtl/io_key_capture.sv
// Memory-mapped debounced key input with sticky press capture and maskable level interrupt.
module io_key_capture
    import io_pio_pkg::*;
#(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          ACTIVE_LOW      = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    io_key_capture_if.slave  bus,
    input  logic [WIDTH-1:0] pio
);

    logic [WIDTH-1:0] level;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;
    logic             wr_edge, wr_mask;
    logic             unused_datain;

    for (genvar i = 0; i < WIDTH; i++) begin : g_key
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .pin       (pio[i]),
            .stable    (level[i]),
            .rise_pulse(rise[i])
        );
    end

    assign wr_edge       = bus.we && (bus.addr == REG_EDGE);
    assign wr_mask       = bus.we && (bus.addr == REG_MASK);
    assign unused_datain = ^bus.datain;

    always_comb begin
        cap_d = cap_q;
        if (wr_edge) begin
            cap_d = cap_q & ~bus.datain[WIDTH-1:0];
        end
        // A press in the same cycle as a clear keeps the bit set.
        cap_d = cap_d | rise;

        mask_d = mask_q;
        if (wr_mask) begin
            mask_d = bus.datain[WIDTH-1:0];
        end

        irq_d = |(cap_q & mask_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_q  <= '0;
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            cap_q  <= cap_d;
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    always_comb begin
        bus.dataout = '0;
        case (bus.addr)
            REG_DATA: bus.dataout = 32'(level);
            REG_EDGE: bus.dataout = 32'(cap_q);
            REG_MASK: bus.dataout = 32'(mask_q);
            default:  bus.dataout = '0;
        endcase
    end

    assign bus.irq = irq_q;

endmodule

// File: tb/tb_io_key_capture.sv
// Directed bench for io_key_capture with a 4-cycle debounce window and active-low keys.
module tb_io_key_capture;
    import io_pio_pkg::*;

    logic       clk;
    logic       reset;
    logic [3:0] pio;
    int         n_vec;
    int         n_err;
    logic [31:0] rdata;
    logic [31:0] seen;

    io_key_capture_if bus ();

    io_key_capture #(
        .WIDTH          (4),
        .DEBOUNCE_CYCLES(4),
        .ACTIVE_LOW     (1'b1)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus),
        .pio  (pio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.dataout;
    endtask

    // Write is presented before the next edge and retired just after it.
    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        bus.addr   = a;
        bus.datain = d;
        bus.we     = 1'b1;
        @(posedge clk);
        #1;
        bus.we     = 1'b0;
        bus.datain = '0;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        reset      = 1'b1;
        pio        = 4'hF;
        bus.addr   = '0;
        bus.datain = '0;
        bus.we     = 1'b0;
        cyc(3);
        reset = 1'b0;

        // 1. idle after reset
        rd(REG_DATA, rdata); check("reset_data", rdata, 32'h0);
        rd(REG_EDGE, rdata); check("reset_edge", rdata, 32'h0);
        rd(REG_MASK, rdata); check("reset_mask", rdata, 32'h0);
        check("reset_irq", {31'b0, bus.irq}, 32'h0);
        seen = '0;
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            rd(REG_DATA, rdata);
            seen = seen | rdata | {31'b0, bus.irq};
            rd(REG_EDGE, rdata);
            seen = seen | rdata;
        end
        check("idle_quiet", seen, 32'h0);

        // 2. key0 press, accepted on the 6th edge
        pio = 4'hE;
        cyc(5);
        rd(REG_DATA, rdata); check("press0_early", rdata, 32'h0);
        cyc(1);
        rd(REG_DATA, rdata); check("press0_data", rdata, 32'h1);
        rd(REG_EDGE, rdata); check("press0_edge", rdata, 32'h1);
        cyc(2);
        check("press0_irq_masked", {31'b0, bus.irq}, 32'h0);

        // 3. 3-cycle glitch on key1 rejected
        pio = 4'hC;
        cyc(3);
        pio  = 4'hE;
        seen = '0;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            rd(REG_DATA, rdata);
            seen = seen | rdata;
            rd(REG_EDGE, rdata);
            seen = seen | rdata;
        end
        check("glitch3_rejected", seen & 32'h2, 32'h0);

        // 4-cycle low on key1 is accepted, its release later is not captured
        pio = 4'hC;
        cyc(4);
        pio = 4'hE;
        cyc(2);
        rd(REG_DATA, rdata); check("glitch4_data", rdata, 32'h3);
        rd(REG_EDGE, rdata); check("glitch4_edge", rdata, 32'h3);
        cyc(6);
        rd(REG_DATA, rdata); check("release1_data", rdata, 32'h1);
        rd(REG_EDGE, rdata); check("release1_edge", rdata, 32'h3);

        // 4. mask and W1C drive irq one cycle later
        wr(REG_MASK, 32'h1);
        check("mask_irq_lag", {31'b0, bus.irq}, 32'h0);
        cyc(1);
        check("mask_irq_set", {31'b0, bus.irq}, 32'h1);
        wr(REG_EDGE, 32'h1);
        rd(REG_EDGE, rdata); check("w1c_edge", rdata, 32'h2);
        cyc(1);
        check("w1c_irq_clear", {31'b0, bus.irq}, 32'h0);
        wr(REG_MASK, 32'hFFFF_FFF0);
        rd(REG_MASK, rdata); check("mask_upper_ignored", rdata, 32'h0000_0000);
        wr(REG_MASK, 32'hFFFF_FFFF);
        rd(REG_MASK, rdata); check("mask_all", rdata, 32'hF);
        cyc(1);
        check("mask_all_irq", {31'b0, bus.irq}, 32'h1);
        wr(REG_DATA, 32'hF);
        rd(REG_DATA, rdata); check("data_ro", rdata, 32'h1);
        wr(8'h0C, 32'hFFFF_FFFF);
        rd(8'h0C, rdata); check("unmapped_read", rdata, 32'h0);
        rd(REG_EDGE, rdata); check("unmapped_wr_edge", rdata, 32'h2);
        wr(REG_EDGE, 32'hF);
        rd(REG_EDGE, rdata); check("w1c_all", rdata, 32'h0);
        cyc(1);
        check("w1c_all_irq", {31'b0, bus.irq}, 32'h0);

        // 5. clear of bit2 in the exact acceptance cycle loses to the press
        pio = 4'hA;
        cyc(5);
        wr(REG_EDGE, 32'h4);
        rd(REG_EDGE, rdata); check("race_edge", rdata, 32'h4);
        rd(REG_DATA, rdata); check("race_data", rdata, 32'h5);
        wr(REG_EDGE, 32'h4);
        rd(REG_EDGE, rdata); check("race_then_clear", rdata, 32'h0);

        // 6. reset while key3 is mid-count
        pio = 4'h2;
        cyc(4);
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
        rd(REG_DATA, rdata); check("rst_data", rdata, 32'h0);
        rd(REG_EDGE, rdata); check("rst_edge", rdata, 32'h0);
        rd(REG_MASK, rdata); check("rst_mask", rdata, 32'h0);
        check("rst_irq", {31'b0, bus.irq}, 32'h0);
        cyc(5);
        rd(REG_DATA, rdata); check("held_early", rdata, 32'h0);
        cyc(1);
        rd(REG_DATA, rdata); check("held_data", rdata, 32'hD);
        rd(REG_EDGE, rdata); check("held_edge", rdata, 32'hD);
        cyc(1);
        check("held_irq_masked", {31'b0, bus.irq}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
